// File: rtl/uart_event_pkg.sv
// Shared event-byte definitions for the host UART event link.
package uart_event_pkg;

  typedef logic [7:0] event_byte_t;

  // End-of-period marker; press bytes may never take this value.
  localparam event_byte_t SYNC_MARKER = 8'hFF;

  // True when a press byte collides with the reserved sync marker.
  function automatic logic is_reserved(input event_byte_t b);
    return (b == SYNC_MARKER);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous power-of-two FIFO holding queued press bytes.
module event_fifo
  import uart_event_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  event_byte_t                  push_data,
  input  logic                         pop,
  output event_byte_t                  head_c,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  event_byte_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push_c;
  logic          do_pop_c;
  logic [LW-1:0] level_next_c;

  // Guard push/pop against full/empty and compute the next occupancy.
  always_comb begin
    do_push_c    = 1'b0;
    do_pop_c     = 1'b0;
    level_next_c = level;
    do_pop_c     = pop && !empty;
    do_push_c    = push && (!full || do_pop_c);
    case ({do_push_c, do_pop_c})
      2'b10:   level_next_c = level + LW'(1);
      2'b01:   level_next_c = level - LW'(1);
      default: level_next_c = level;
    endcase
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next_c;
      full  <= (level_next_c == LW'(DEPTH));
      empty <= (level_next_c == LW'(0));
    end
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/uart_event_queue.sv
// Queues press bytes and sync markers and hands them to uart_tx one at a time.
module uart_event_queue
  import uart_event_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_BEATS = 16
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             press_event,
  input  logic [7:0]                       press_data,
  input  logic [$clog2(NUM_BEATS)-1:0]     beat_count,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic [7:0]                       drop_count,
  output logic                             overflow
);

  localparam int unsigned BW = $clog2(NUM_BEATS);

  logic [BW-1:0] beat_prev;
  logic          sync_pending;
  logic          fifo_full;
  logic          fifo_empty;
  event_byte_t   fifo_head_c;

  logic          wrap_c;
  logic          load_c;
  logic          take_sync_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;

  // Arbitration: sync beats the FIFO head; a pop frees room for a same-cycle push.
  always_comb begin
    wrap_c      = 1'b0;
    load_c      = 1'b0;
    take_sync_c = 1'b0;
    pop_c       = 1'b0;
    push_c      = 1'b0;
    drop_c      = 1'b0;
    wrap_c      = (beat_count == BW'(0)) && (beat_prev == BW'(NUM_BEATS - 1));
    load_c      = !tx_valid || tx_ready;
    take_sync_c = load_c && sync_pending;
    pop_c       = load_c && !sync_pending && !fifo_empty;
    push_c      = press_event && !is_reserved(press_data) && (!fifo_full || pop_c);
    drop_c      = press_event && !push_c;
  end

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_c),
    .push_data (press_data),
    .pop       (pop_c),
    .head_c    (fifo_head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Beat history and pending-sync flag; a new wrap re-arms even while one is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_prev    <= '0;
      sync_pending <= 1'b0;
    end else begin
      beat_prev <= beat_count;
      if (wrap_c) begin
        sync_pending <= 1'b1;
      end else if (take_sync_c) begin
        sync_pending <= 1'b0;
      end
    end
  end

  // Output register; holds its byte while uart_tx stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (load_c) begin
      if (sync_pending) begin
        tx_data  <= SYNC_MARKER;
        tx_valid <= 1'b1;
      end else if (!fifo_empty) begin
        tx_data  <= fifo_head_c;
        tx_valid <= 1'b1;
      end else begin
        tx_valid <= 1'b0;
      end
    end
  end

  // Loss accounting: saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_count <= 8'h00;
      overflow   <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_event_queue.sv
// Scoreboard bench for uart_event_queue.
module tb_uart_event_queue;
  import uart_event_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned NUM_BEATS = 16;

  logic       clk         = 1'b0;
  logic       rstn        = 1'b0;
  logic       press_event = 1'b0;
  logic [7:0] press_data  = 8'h00;
  logic [3:0] beat_count  = 4'd0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready    = 1'b0;
  logic [3:0] level;
  logic [7:0] drop_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int x0       = 0;
  logic [7:0] exp_q [$];

  uart_event_queue #(
    .DEPTH     (DEPTH),
    .NUM_BEATS (NUM_BEATS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .press_event (press_event),
    .press_data  (press_data),
    .beat_count  (beat_count),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .level       (level),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #41 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    press_event = 1'b0;
    beat_count  = 4'd0;
    rstn        = 1'b0;
    exp_q.delete();
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic press(input logic [7:0] b, input logic expect_out);
    press_data  = b;
    press_event = 1'b1;
    if (expect_out) exp_q.push_back(b);
  endtask

  // Transfer monitor: every accepted byte must match the scoreboard head.
  always @(negedge clk) begin
    if (rstn && tx_valid && tx_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) cyc();
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rstn = 1'b1;
    cyc();

    // Single press latency
    tx_ready = 1'b1;
    press(8'h3A, 1'b1);
    cyc();
    press_event = 1'b0;
    chk("t1_n1_valid", 32'(tx_valid), 32'd0);
    cyc();
    chk("t1_n2_valid", 32'(tx_valid), 32'd1);
    chk("t1_n2_data", 32'(tx_data), 32'h3A);
    cyc();
    chk("t1_n3_valid", 32'(tx_valid), 32'd0);
    chk("t1_level", 32'(level), 32'd0);

    // Beat wrap 14,15,0 -> one sync marker
    beat_count = 4'd14;
    cyc();
    beat_count = 4'd15;
    cyc();
    beat_count = 4'd0;
    exp_q.push_back(SYNC_MARKER);
    x0 = xfer_cnt;
    cyc();
    chk("t2_n1_valid", 32'(tx_valid), 32'd0);
    cyc();
    chk("t2_n2_valid", 32'(tx_valid), 32'd1);
    chk("t2_n2_data", 32'(tx_data), 32'hFF);
    repeat (4) cyc();
    chk("t2_one_sync", 32'(xfer_cnt - x0), 32'd1);

    // Sync and press in the same cycle
    beat_count = 4'd15;
    cyc();
    beat_count = 4'd0;
    exp_q.push_back(SYNC_MARKER);
    press(8'h12, 1'b1);
    cyc();
    press_event = 1'b0;
    cyc();
    chk("t3_first", 32'(tx_data), 32'hFF);
    chk("t3_first_v", 32'(tx_valid), 32'd1);
    cyc();
    chk("t3_second", 32'(tx_data), 32'h12);
    chk("t3_second_v", 32'(tx_valid), 32'd1);
    cyc();
    chk("t3_idle", 32'(tx_valid), 32'd0);

    // Overfill with the UART stalled
    tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      press(8'(i), (i <= 9));
      cyc();
    end
    press_event = 1'b0;
    chk("t4_hold_data", 32'(tx_data), 32'h01);
    chk("t4_hold_valid", 32'(tx_valid), 32'd1);
    chk("t4_level", 32'(level), 32'd8);
    chk("t4_drop", 32'(drop_count), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd1);
    cyc();
    chk("t4_stable", 32'(tx_data), 32'h01);
    x0 = xfer_cnt;
    tx_ready = 1'b1;
    repeat (12) cyc();
    chk("t4_drain_cnt", 32'(xfer_cnt - x0), 32'd9);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reserved byte and counter saturation
    do_reset();
    tx_ready = 1'b1;
    x0 = xfer_cnt;
    press(8'hFF, 1'b0);
    cyc();
    press_event = 1'b0;
    repeat (4) cyc();
    chk("t5_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    chk("t5_drop", 32'(drop_count), 32'd1);
    chk("t5_ovf", 32'(overflow), 32'd1);
    chk("t5_level", 32'(level), 32'd0);
    press(8'hFF, 1'b0);
    repeat (300) cyc();
    press_event = 1'b0;
    cyc();
    chk("t5_saturate", 32'(drop_count), 32'd255);

    // Reset while a byte is offered and four are queued
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(8'h41 + 8'(i), 1'b1);
      cyc();
    end
    press_event = 1'b0;
    cyc();
    chk("t6_pre_valid", 32'(tx_valid), 32'd1);
    chk("t6_pre_level", 32'(level), 32'd4);
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", 32'(tx_valid), 32'd0);
    exp_q.delete();
    repeat (2) cyc();
    rstn = 1'b1;
    x0 = xfer_cnt;
    tx_ready = 1'b1;
    repeat (6) cyc();
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_drop", 32'(drop_count), 32'd0);
    chk("t6_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    chk("t6_idle", 32'(tx_valid), 32'd0);
    press(8'h77, 1'b1);
    cyc();
    press_event = 1'b0;
    repeat (4) cyc();
    chk("t6_new_press", 32'(xfer_cnt - x0), 32'd1);

    // Back-to-back throughput
    x0 = xfer_cnt;
    for (int i = 0; i < 6; i++) begin
      press(8'h50 + 8'(i), 1'b1);
      cyc();
    end
    press_event = 1'b0;
    chk("t7_midway", 32'(xfer_cnt - x0), 32'd4);
    repeat (3) cyc();
    chk("t7_total", 32'(xfer_cnt - x0), 32'd6);

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
